uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 104 ++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that feeds a UART transmitter via a start/done handshake.
// Optional macro UART_TX_FEEDER_RETRY_EN resends a failed byte up to 3 times before flagging an error.
module uart_tx_feeder #(
   parameter int DEPTH = 16,
   parameter int AW = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic wr_en,
   input  logic [7:0] wr_data,
   output logic full,
   output logic empty,
   output logic [AW:0] count,
   output logic overflow,
   output logic tx_start,
   output logic [7:0] tx_data,
   input  logic tx_done,
   input  logic tx_err,
   output logic err_flag
);
   typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
   state_t state;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic done_q;
   logic done_rise;
   logic push;
   logic pop;
`ifdef UART_TX_FEEDER_RETRY_EN
   logic [1:0] retry_cnt;
   logic resend;
`endif
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign push = wr_en && !full;
   assign pop = state == LOAD;
   assign done_rise = tx_done && !done_q;
   // storage array; contents are left untouched by reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end
   // circular pointers, occupancy and sticky overflow (full is judged before the edge)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (wr_en && full) overflow <= 1'b1;
      end
   end
   // sequencer: IDLE -> LOAD (pop head) -> SEND (hold start until done edge) -> GAP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         tx_start <= 1'b0;
         tx_data <= 8'h00;
         err_flag <= 1'b0;
         done_q <= 1'b0;
`ifdef UART_TX_FEEDER_RETRY_EN
         retry_cnt <= 2'd0;
         resend <= 1'b0;
`endif
      end else begin
         done_q <= tx_done;
         case (state)
            IDLE: if (!empty) state <= LOAD;
            LOAD: begin
               tx_data <= mem[rd_ptr];
               tx_start <= 1'b1;
               state <= SEND;
`ifdef UART_TX_FEEDER_RETRY_EN
               retry_cnt <= 2'd0;
`endif
            end
            SEND: if (done_rise) begin
               tx_start <= 1'b0;
               state <= GAP;
`ifdef UART_TX_FEEDER_RETRY_EN
               resend <= tx_err && retry_cnt != 2'd3;
               if (tx_err && retry_cnt != 2'd3) retry_cnt <= retry_cnt + 2'd1;
               if (tx_err && retry_cnt == 2'd3) err_flag <= 1'b1;
`else
               if (tx_err) err_flag <= 1'b1;
`endif
            end
            GAP: begin
`ifdef UART_TX_FEEDER_RETRY_EN
               state <= resend ? SEND : IDLE;
               tx_start <= resend;
`else
               state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
